// File: rtl/ser_comm_pkg.sv
// Shared types and constants for the bit-serial frame receiver/forwarder.
package ser_comm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam logic [7:0] FLAG_BYTE  = 8'h7E;
  localparam logic [7:0] ABORT_BYTE = 8'h81;

endpackage

// File: rtl/ser_pattern_shreg.sv
// 8-bit serial pattern window with synchronous clear and flag/abort compare.
// Abort compare exists only when SER_ABORT_DETECT_EN is defined.
module ser_pattern_shreg
  import ser_comm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       clr,
  output logic [7:0] win_next,
  output logic       is_flag,
  output logic       is_abort
);

  logic [7:0] shreg;

  assign win_next = {shreg[6:0], din};
  assign is_flag  = (win_next == FLAG_BYTE);

`ifdef SER_ABORT_DETECT_EN
  assign is_abort = (win_next == ABORT_BYTE);
`else
  assign is_abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      shreg <= '0;
    else if (clr)  shreg <= '0;
    else           shreg <= win_next;
  end

endmodule

// File: rtl/ser_communication.sv
// Bit-serial frame receiver: hunts for flag 0x7E, forwards PAYLOAD_BITS bits.
// Define SER_ABORT_DETECT_EN to drop frames on an in-payload 0x81 abort byte.
module ser_communication
  import ser_comm_pkg::*;
#(
  parameter int PAYLOAD_BITS = 96,
  parameter int CNT_W        = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic RcIn,
  output logic txOut,
  output logic txValid,
  output logic txAbort
);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               tx_out_d, tx_valid_d, tx_abort_d;
  logic               clr;
  logic [7:0]         win_next;
  logic               is_flag, is_abort;

  ser_pattern_shreg u_shreg (
    .clk      (clk),
    .rst      (rst),
    .din      (RcIn),
    .clr      (clr),
    .win_next (win_next),
    .is_flag  (is_flag),
    .is_abort (is_abort)
  );

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    tx_out_d   = txOut;
    tx_valid_d = 1'b0;
    tx_abort_d = 1'b0;
    clr        = 1'b0;
    unique case (state)
      HUNT: begin
        if (is_flag) begin
          state_d = DATA;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      DATA: begin
        if (is_abort) begin
          // Abort wins over a normal end on the final payload bit.
          tx_abort_d = 1'b1;
          state_d    = HUNT;
          cnt_d      = '0;
          clr        = 1'b1;
        end else begin
          tx_out_d   = win_next[0];
          tx_valid_d = 1'b1;
          if (cnt == CNT_W'(PAYLOAD_BITS - 1)) begin
            // Window restarts from zero so the next flag must arrive whole.
            state_d = HUNT;
            cnt_d   = '0;
            clr     = 1'b1;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= HUNT;
      cnt     <= '0;
      txOut   <= 1'b0;
      txValid <= 1'b0;
      txAbort <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      txOut   <= tx_out_d;
      txValid <= tx_valid_d;
      txAbort <= tx_abort_d;
    end
  end

endmodule

// File: tb/tb_ser_communication.sv
// Scoreboard bench for ser_communication; expectations come from a bit-level
// reference model pushed per driven bit and popped after each output edge.
module tb_ser_communication;

  localparam int PB = 96;
`ifdef SER_ABORT_DETECT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef struct packed {
    logic valid;
    logic abort;
    logic out;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic RcIn;
  logic txOut, txValid, txAbort;

  ser_communication #(.PAYLOAD_BITS(PB), .CNT_W(7)) dut (
    .clk     (clk),
    .rst     (rst),
    .RcIn    (RcIn),
    .txOut   (txOut),
    .txValid (txValid),
    .txAbort (txAbort)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Reference model state
  bit       m_hunt;
  bit [7:0] m_win;
  int       m_fwd;
  bit       m_out;
  int       zrun;
  int       vcnt, acnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hunt = 1'b1;
    m_win  = 8'h00;
    m_fwd  = 0;
    m_out  = 1'b0;
    sb_q.delete();
  endfunction

  function automatic void model_step(input bit b);
    bit [7:0] nxt;
    exp_t     e;
    nxt = {m_win[6:0], b};
    e   = '0;
    if (m_hunt) begin
      if (nxt == 8'h7E) begin
        m_hunt = 1'b0;
        m_win  = 8'h00;
        m_fwd  = 0;
      end else begin
        m_win = nxt;
      end
    end else if (ABORT_EN && nxt == 8'h81) begin
      e.abort = 1'b1;
      m_hunt  = 1'b1;
      m_win   = 8'h00;
      m_fwd   = 0;
    end else begin
      e.valid = 1'b1;
      m_out   = b;
      m_fwd++;
      if (m_fwd == PB) begin
        m_hunt = 1'b1;
        m_win  = 8'h00;
        m_fwd  = 0;
      end else begin
        m_win = nxt;
      end
    end
    e.out = m_out;
    sb_q.push_back(e);
  endfunction

  // Random payload bit with zero runs capped at 5, so no accidental 0x81.
  function automatic bit rnd_bit();
    bit b;
    b = 1'($urandom_range(0, 1));
    if (zrun >= 5) b = 1'b1;
    zrun = b ? 0 : zrun + 1;
    return b;
  endfunction

  task automatic send_bit(input bit b);
    exp_t e;
    RcIn = b;
    model_step(b);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("valid", 32'(txValid), 32'(e.valid));
      check("abort", 32'(txAbort), 32'(e.abort));
      check("out",   32'(txOut),   32'(e.out));
    end
    if (txValid === 1'b1) vcnt++;
    if (txAbort === 1'b1) acnt++;
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic [7:0] t;
    t = v;
    for (int i = 7; i >= 0; i--) send_bit(t[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_rnd(input int n);
    zrun = 0;
    for (int i = 0; i < n; i++) send_bit(rnd_bit());
  endtask

  initial begin
    void'($urandom(32'h5E7C_0A11));
    rst  = 1'b0;
    RcIn = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(txValid), 32'd0);
    check("rst_abort", 32'(txAbort), 32'd0);
    check("rst_out",   32'(txOut),   32'd0);
    rst = 1'b1;

    // Idle zeros
    vcnt = 0; acnt = 0;
    send_zeros(10);
    check("idle_valid_cnt", 32'(vcnt), 32'd0);
    check("idle_abort_cnt", 32'(acnt), 32'd0);

    // Normal frame: flag then 97 bits; only 96 are valid
    vcnt = 0; acnt = 0;
    send_byte(8'h7E);
    send_rnd(PB + 1);
    send_zeros(12);
    check("frame_valid_cnt", 32'(vcnt), 32'(PB));
    check("frame_abort_cnt", 32'(acnt), 32'd0);

    // Abort frame, padded so the macro-off build completes its frame
    vcnt = 0; acnt = 0;
    send_zeros(20);
    send_byte(8'h7E);
    send_rnd(40);
    send_byte(8'h81);
    send_zeros(PB - 48 + 20);
    check("abort_valid_cnt", 32'(vcnt), ABORT_EN ? 32'd47 : 32'(PB));
    check("abort_pulse_cnt", 32'(acnt), ABORT_EN ? 32'd1 : 32'd0);

    // Fresh frame after the abort
    vcnt = 0; acnt = 0;
    send_byte(8'h7E);
    send_rnd(PB);
    send_zeros(4);
    check("refresh_valid_cnt", 32'(vcnt), 32'(PB));
    check("refresh_abort_cnt", 32'(acnt), 32'd0);

    // Reset mid-frame while a 0x7E pattern is half received in the payload
    send_zeros(5);
    send_byte(8'h7E);
    send_rnd(20);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("pre_rst_valid", 32'(txValid), 32'd1);
    check("pre_rst_out",   32'(txOut),   32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(txValid), 32'd0);
    check("async_rst_abort", 32'(txAbort), 32'd0);
    check("async_rst_out",   32'(txOut),   32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    vcnt = 0; acnt = 0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    send_zeros(10);
    check("post_rst_valid_cnt", 32'(vcnt), 32'd0);
    check("post_rst_abort_cnt", 32'(acnt), 32'd0);

    // A full flag after reset starts a frame again
    vcnt = 0;
    send_byte(8'h7E);
    send_rnd(PB);
    send_zeros(3);
    check("post_rst_frame_cnt", 32'(vcnt), 32'(PB));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ser_communication.md
Name: ser_communication

Overview:
- Bit-serial frame receiver/forwarder, one bit per clock.
- Hunts the input stream for the flag byte 0x7E (01111110, MSB first).
- After a flag, forwards a fixed-length payload to txOut and qualifies each bit with txValid.
- Detects the abort byte 0x81 (10000001) inside a payload, pulses txAbort and drops the frame. Sits between the serial line sampler and the downstream frame consumer.

Parameters:
- PAYLOAD_BITS, 96: number of payload bits forwarded after each flag.
- CNT_W, 7: width of the payload bit counter; must satisfy 2^CNT_W >= PAYLOAD_BITS.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- RcIn  in  1  received serial bit, sampled every rising clk edge.
- txOut  out  1  forwarded payload bit (registered).
- txValid  out  1  high while txOut carries a payload bit.
- txAbort  out  1  one-cycle pulse when an abort byte terminates a frame.

Behaviour:
- Reset (rst=0, asynchronous): state=HUNT, shift register=0x00, counter=0, txOut=0, txValid=0, txAbort=0.
- Window: win_next = {shreg[6:0], RcIn}. shreg <= win_next every cycle unless cleared as stated below.
- States: HUNT and DATA.
- HUNT:
  - txValid=0.
  - If win_next==0x7E: go to DATA, clear shreg to 0x00 and clear counter.
  - Leading and idle zeros never match the flag.
- DATA, every cycle:
  - txOut<=RcIn and txValid<=1, so output latency is 1 cycle.
  - counter increments.
  - The first payload bit is the bit sampled the cycle after the flag's last bit.
- DATA end: when counter==PAYLOAD_BITS-1 at an edge, that bit is still forwarded, then state goes to HUNT. txValid is low from the following cycle, so exactly PAYLOAD_BITS valid cycles occur per frame.
- Abort: in DATA, if win_next==0x81 (and ABORT_DETECT_EN is defined):
  - txAbort<=1 for exactly one cycle.
  - txValid<=0 in that same cycle and the bit is not forwarded.
  - state goes to HUNT, shreg is cleared, counter is cleared.
  - The preceding 7 abort-pattern bits have already been forwarded; the consumer discards the frame on txAbort.
- Clearing shreg on flag detection guarantees no abort match can span the flag. Abort needs 8 payload bits minimum.
- Abort on the final payload bit: abort has priority over normal end.
- A 0x7E pattern inside DATA is treated as payload. There is no bit-stuffing and no resynchronisation.
- Back-to-back frames: after a frame ends, the window is zero-based, so a following flag needs all 8 of its bits received in HUNT.
- txOut holds its last value when txValid=0.
- txAbort is 0 outside the pulse cycle.
- Reset asserted mid-frame aborts silently: no txAbort pulse; all outputs go to their reset values immediately.

Optional Feature:
- Macro SER_ABORT_DETECT_EN.
- Defined: abort detection as described above.
- Undefined: no abort comparison logic; txAbort is tied to 0; 0x81 inside a payload is forwarded as ordinary data and frames always run PAYLOAD_BITS.

Decomposition:
- Package ser_comm_pkg: state enum (HUNT, DATA), FLAG_BYTE=8'h7E, ABORT_BYTE=8'h81.
- One sub-module, ser_pattern_shreg: the 8-bit shift register with synchronous clear input, exposing win_next and compare outputs is_flag and is_abort.
- Top module holds the FSM, the counter and the output registers.

Test Plan:
- Idle: rst low then high, 10 zeros on RcIn -> txValid, txAbort and txOut stay 0.
- Normal frame: flag 01111110, then 97 random bits -> txValid high for exactly 96 consecutive cycles starting 1 cycle after the first payload bit. txOut equals RcIn delayed 1 cycle. The 97th bit is not valid. txAbort stays 0.
- Abort frame: 20 zeros, flag, 40 random bits, then 10000001 -> txAbort pulses 1 cycle on the edge sampling the final '1'. txValid falls in that cycle. The counter had not reached 96.
- Post-abort hunt: 20 zeros after the abort -> no txValid. A new flag then starts a fresh 96-bit frame.
- Reset mid-frame: drop rst during DATA -> outputs go to 0 asynchronously, no txAbort. After release, a payload tail containing 0x7E does not start a frame unless a full flag is seen in HUNT.
- Macro off (SER_ABORT_DETECT_EN undefined): same abort stimulus -> txAbort stays 0 and 0x81 appears on txOut with txValid=1.
